boot_loader: RTL
================

Name: boot_loader

Overview:
Program-image loader that sits directly upstream of the datapath RAM and control unit.
- Accepts 32-bit instruction words over a valid/ready stream.
- Writes each word into byte-addressed RAM, big-endian: the MSB byte goes to the lowest address.
- Holds the CPU in reset while loading, then releases it.
- Replaces the behavioural file-to-Mem preload with synthesizable hardware.

Parameters:
- ADDR_WIDTH, 9: RAM byte-address width.
- MEM_BYTES, 512: RAM size in bytes. Writes at or beyond this are illegal.
- BASE_ADDR, 0: first byte address written. Must be a multiple of 4.
- CPU_RST_CYCLES, 2: cycles cpu_reset stays high after the last byte is written. Minimum 1.

Ports:
- Clk  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- word_valid  in  1  word_data is valid.
- word_data  in  32  instruction word.
- word_last  in  1  marks the final word of the image; sampled with the word.
- word_ready  out  1  loader can accept a word.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_byte  out  8  RAM write data.
- ram_we  out  1  RAM byte write enable.
- cpu_reset  out  1  active-high reset to the control unit.
- busy  out  1  a load is in progress.
- done  out  1  image loaded and CPU released.
- error  out  1  image overflowed MEM_BYTES.
- word_count  out  ADDR_WIDTH-1  words fully written.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, addr=BASE_ADDR, byte_idx=0, word_count=0.
  - word_ready=0, ram_we=0, ram_addr=0, ram_byte=0, busy=0, done=0, error=0.
  - cpu_reset=1.
- All outputs are registered.
- IDLE:
  - cpu_reset=1.
  - start=1 → WAIT; addr←BASE_ADDR, word_count←0.
- WAIT:
  - word_ready=1, busy=1.
  - A handshake is word_valid=1 with word_ready=1.
  - On handshake, capture word_data and word_last.
  - If addr+4 > MEM_BYTES, go to ERROR; nothing is written.
  - Otherwise go to WRITE with byte_idx=0.
  - word_valid=0: stay in WAIT; an unbounded gap is legal.
- WRITE (4 cycles):
  - word_ready=0, ram_we=1.
  - ram_addr=addr+byte_idx.
  - ram_byte = word[31:24], then [23:16], [15:8], [7:0] for byte_idx 0..3.
  - After byte_idx=3: addr←addr+4 and word_count←word_count+1, both effective the next cycle.
  - Then go to HOLD if the captured last flag is set, else WAIT.
  - Input stalls for the whole 4-cycle window; word_valid held by the source is simply not taken.
- Throughput: at most one word per 5 cycles (1 accept + 4 writes).
- HOLD:
  - ram_we=0, cpu_reset=1, busy=1.
  - Counter runs CPU_RST_CYCLES cycles, then → DONE.
- DONE:
  - cpu_reset=0, done=1, busy=0.
  - word_count and addr are frozen.
  - start=1 begins a reload:
    - addr←BASE_ADDR, word_count←0.
    - done←0 and cpu_reset←1 in the same edge.
    - → WAIT.
- ERROR:
  - error=1, cpu_reset=1, busy=0, word_ready=0.
  - start is ignored. Exit only via RESET.
- start is ignored in WAIT, WRITE and HOLD.
- Width rule: addr wraps modulo 2^ADDR_WIDTH. The overflow check uses an ADDR_WIDTH+1-bit compare, so the boundary is detected before any wrap.
- Exact fit: an image ending exactly at MEM_BYTES is legal. The final word is written to MEM_BYTES-4..MEM_BYTES-1, then → HOLD.
- Reset mid-WRITE:
  - ram_we drops asynchronously.
  - Bytes already written stay in RAM; the partial word is not counted.
  - cpu_reset stays 1.
- A word presented with word_valid=1 during the same edge that start is accepted is not taken; ready is first high in WAIT.

Test Plan:
1. Single word: start; 0x82100005 with last=1 → bytes at addr 0..3 are 82,10,00,05 on 4 consecutive ram_we cycles. cpu_reset stays high 2 more cycles, then done=1, word_count=1.
2. Three-word image with random valid gaps and word_valid held through WRITE: 0xA0102007, 0xA2102003, 0x81C3E008 → bytes 0..11 correct, no duplicate writes, word_count=3, done=1.
3. Overflow with MEM_BYTES=8: send 3 words → first two written to 0..7, third never written. error=1, word_count=2, cpu_reset=1, done=0; start afterwards has no effect.
4. Exact fit with MEM_BYTES=8, 2 words, last on the second → done=1, no error.
5. RESET pulsed low during byte_idx=2 → ram_we falls immediately, all outputs at reset values, RAM bytes 0..1 of that word written. A fresh start reloads from BASE_ADDR.
6. Reload after DONE: start → cpu_reset rises the next cycle, done=0, word_count=0. A new single-word image with BASE_ADDR=384 lands at 384..387.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: streams 32-bit instruction words into byte-addressed RAM
// (big-endian, MSB byte at the lowest address) while holding the CPU in
// reset, then releases the CPU once the image is loaded.
module boot_loader #(
    parameter int ADDR_WIDTH     = 9,
    parameter int MEM_BYTES      = 512,
    parameter int BASE_ADDR      = 0,
    parameter int CPU_RST_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    input  logic                  word_last,
    output logic                  word_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_byte,
    output logic                  ram_we,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-2:0] word_count
);

    localparam int                  WCW       = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LIMIT   = (ADDR_WIDTH + 1)'(MEM_BYTES);
    localparam logic [15:0]           HOLD_LAST = 16'(CPU_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [1:0]              byte_idx;
    logic [31:0]             word_reg;
    logic                    last_reg;
    logic [15:0]             hold_cnt;
    logic [ADDR_WIDTH:0]     word_end;
    logic                    overflow;
    logic                    handshake;

    // Big-endian byte lane select: index 0 is the most significant byte.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // One bit wider than addr so a word ending past MEM_BYTES is caught before addr wraps.
    always_comb begin
        word_end  = {1'b0, addr} + (ADDR_WIDTH + 1)'(4);
        overflow  = (word_end > LIMIT);
        handshake = word_valid & word_ready;
    end

    // Load sequencer with all outputs registered; the write strobe for a byte
    // is set up on the edge before that byte's cycle so ram_we spans exactly 4 cycles.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            addr       <= BASE;
            byte_idx   <= '0;
            word_reg   <= '0;
            last_reg   <= 1'b0;
            hold_cnt   <= '0;
            word_count <= '0;
            word_ready <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_byte   <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cpu_reset <= 1'b1;
                    if (start) begin
                        state      <= S_WAIT;
                        addr       <= BASE;
                        word_count <= '0;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (handshake) begin
                        word_reg   <= word_data;
                        last_reg   <= word_last;
                        word_ready <= 1'b0;
                        if (overflow) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_WRITE;
                            byte_idx <= '0;
                            ram_we   <= 1'b1;
                            ram_addr <= addr;
                            ram_byte <= word_data[31:24];
                        end
                    end
                end

                S_WRITE: begin
                    if (byte_idx == 2'd3) begin
                        ram_we     <= 1'b0;
                        addr       <= addr + ADDR_WIDTH'(4);
                        word_count <= word_count + WCW'(1);
                        if (last_reg) begin
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                        end else begin
                            state      <= S_WAIT;
                            word_ready <= 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        ram_addr <= addr + ADDR_WIDTH'(byte_idx + 2'd1);
                        ram_byte <= pick_byte(word_reg, byte_idx + 2'd1);
                    end
                end

                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_DONE;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        state      <= S_WAIT;
                        addr       <= BASE;
                        word_count <= '0;
                        done       <= 1'b0;
                        cpu_reset  <= 1'b1;
                        busy       <= 1'b1;
                        word_ready <= 1'b1;
                    end
                end

                S_ERROR: begin
                    error      <= 1'b1;
                    cpu_reset  <= 1'b1;
                    busy       <= 1'b0;
                    word_ready <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
